hazard_ctrl: RTL and testbench

- Pipeline control for the 5-stage core.
- Reads the hazard-relevant fields of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives back the write-enable, flush and bubble controls of those registers, plus operand-forwarding selects.
- Owns load-use stalls, taken-branch flushes and data-memory wait freezes. A watchdog traps a hung data memory.

---
 rtl/hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage core.
//
// Watches the hazard-relevant fields of IF/ID, ID/EX, EX/MEM and MEM/WB.
// From these it drives the load enables, flushes and the MEM/WB bubble of
// those registers, plus the ALU operand-forwarding selects. It handles
// load-use stalls, taken-branch flushes and data-memory wait freezes. A
// watchdog traps a data memory that never acknowledges.
//
// Ports:
//   clk, reset            core clock, asynchronous active-high reset
//   if_id_rs1/rs2         source registers of the instruction in ID
//   id_ex_memread/rd      load flag and destination of the instruction in EX
//   id_ex_rs1/rs2         source registers of the instruction in EX
//   ex_mem_regwrite/rd    write-back intent of the instruction in MEM
//   mem_wb_regwrite/rd    write-back intent of the instruction in WB
//   ex_branch_taken       branch/jump resolved taken in EX
//   dmem_req, dmem_ack    data memory access pending / completing
//   pc_we .. ex_mem_we    register load enables
//   if_id_flush,
//   id_ex_flush           zero the register on the next edge
//   mem_wb_bubble         load MEM/WB with a no-write bubble
//   fwd_a, fwd_b          00 = RD_One/Two, 10 = EX/MEM, 01 = MEM/WB
//   stall_cnt, flush_cnt  saturating performance counters
//   mem_err               sticky watchdog trap
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             mem_wb_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_mem_err;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_err_set;
  logic             w_load_use;
  logic             w_pc_we;
  logic             w_if_id_we;
  logic             w_if_id_flush;
  logic             w_id_ex_we;
  logic             w_id_ex_flush;
  logic             w_ex_mem_we;
  logic             w_bubble;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Forwarding select for one EX source register; the younger EX/MEM
  // result wins over MEM/WB, and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       exm_rw,
    input logic [4:0] exm_rd,
    input logic       mwb_rw,
    input logic [4:0] mwb_rd
  );
    if (exm_rw && (exm_rd != 5'd0) && (exm_rd == rs))
      return 2'b10;
    else if (mwb_rw && (mwb_rd != 5'd0) && (mwb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign w_fwd_a = fwd_sel(id_ex_rs1, ex_mem_regwrite, ex_mem_rd,
                           mem_wb_regwrite, mem_wb_rd);
  assign w_fwd_b = fwd_sel(id_ex_rs2, ex_mem_regwrite, ex_mem_rd,
                           mem_wb_regwrite, mem_wb_rd);

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_err_set     = 1'b0;
    w_pc_we       = 1'b1;
    w_if_id_we    = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_we    = 1'b1;
    w_id_ex_flush = 1'b0;
    w_ex_mem_we   = 1'b1;
    w_bubble      = 1'b0;
    case (r_state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          // Freeze everything up to EX/MEM; branch and load-use are seen
          // again after the wait because ID and EX are held.
          w_pc_we     = 1'b0;
          w_if_id_we  = 1'b0;
          w_id_ex_we  = 1'b0;
          w_ex_mem_we = 1'b0;
          w_bubble    = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = CNT_W'(1);
          w_stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
          // The flush beats the load; a load-use on the discarded
          // younger instruction does not matter.
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_flush_inc   = 1'b1;
        end else if (w_load_use) begin
          w_pc_we       = 1'b0;
          w_if_id_we    = 1'b0;
          w_id_ex_flush = 1'b1;
          w_stall_inc   = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          w_pc_we     = 1'b0;
          w_if_id_we  = 1'b0;
          w_id_ex_we  = 1'b0;
          w_ex_mem_we = 1'b0;
          w_bubble    = 1'b1;
          w_stall_inc = 1'b1;
          if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            w_state_nxt = ERR;
            w_err_set   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
          end
        end
      end
      ERR: begin
        w_pc_we     = 1'b0;
        w_if_id_we  = 1'b0;
        w_id_ex_we  = 1'b0;
        w_ex_mem_we = 1'b0;
        w_bubble    = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall_inc) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_inc) r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_err_set)   r_mem_err   <= 1'b1;
    end
  end

  // Reset forces every control quiet, independent of the state register.
  assign pc_we         = w_pc_we       & ~reset;
  assign if_id_we      = w_if_id_we    & ~reset;
  assign if_id_flush   = w_if_id_flush & ~reset;
  assign id_ex_we      = w_id_ex_we    & ~reset;
  assign id_ex_flush   = w_id_ex_flush & ~reset;
  assign ex_mem_we     = w_ex_mem_we   & ~reset;
  assign mem_wb_bubble = w_bubble      & ~reset;
  assign fwd_a         = reset ? 2'b00 : w_fwd_a;
  assign fwd_b         = reset ? 2'b00 : w_fwd_b;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign mem_err       = r_mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int MEM_TIMEOUT = 4;

  // ctl ordering: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
  //                ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] C_RST  = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0001110;

  typedef struct {
    logic       rst;
    logic [4:0] ifid_rs1, ifid_rs2;
    logic       memread;
    logic [4:0] idex_rd, idex_rs1, idex_rs2;
    logic       exm_rw;
    logic [4:0] exm_rd;
    logic       mwb_rw;
    logic [4:0] mwb_rd;
    logic       br, req, ack;
  } in_t;

  typedef struct {
    string            name;
    logic [6:0]       ctl;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] stall, flush;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0;
  logic id_ex_memread = 1'b0;
  logic [4:0] id_ex_rd = '0, id_ex_rs1 = '0, id_ex_rs2 = '0;
  logic ex_mem_regwrite = 1'b0;
  logic [4:0] ex_mem_rd = '0;
  logic mem_wb_regwrite = 1'b0;
  logic [4:0] mem_wb_rd = '0;
  logic ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_err;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  function automatic in_t idle();
    in_t v;
    v.rst = 1'b0; v.ifid_rs1 = '0; v.ifid_rs2 = '0; v.memread = 1'b0;
    v.idex_rd = '0; v.idex_rs1 = '0; v.idex_rs2 = '0;
    v.exm_rw = 1'b0; v.exm_rd = '0; v.mwb_rw = 1'b0; v.mwb_rd = '0;
    v.br = 1'b0; v.req = 1'b0; v.ack = 1'b0;
    return v;
  endfunction

  function automatic exp_t mk(string nm, logic [6:0] ctl, logic [1:0] fa, logic [1:0] fb,
                              int s, int f, logic err);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.fa = fa; e.fb = fb;
    e.stall = CNT_W'(s); e.flush = CNT_W'(f); e.err = err;
    return e;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle; the monitor checks them mid-cycle.
  task automatic step(input in_t v, input exp_t e);
    reset = v.rst;
    if_id_rs1 = v.ifid_rs1; if_id_rs2 = v.ifid_rs2;
    id_ex_memread = v.memread; id_ex_rd = v.idex_rd;
    id_ex_rs1 = v.idex_rs1; id_ex_rs2 = v.idex_rs2;
    ex_mem_regwrite = v.exm_rw; ex_mem_rd = v.exm_rd;
    mem_wb_regwrite = v.mwb_rw; mem_wb_rd = v.mwb_rd;
    ex_branch_taken = v.br; dmem_req = v.req; dmem_ack = v.ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full control word.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] got;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble};
      checks++;
      if (got !== e.ctl || fwd_a !== e.fa || fwd_b !== e.fb || stall_cnt !== e.stall ||
          flush_cnt !== e.flush || mem_err !== e.err) begin
        errors++;
        $display("FAIL %s: got ctl=%b fa=%b fb=%b stall=%0d flush=%0d err=%b, want ctl=%b fa=%b fb=%b stall=%0d flush=%0d err=%b",
                 e.name, got, fwd_a, fwd_b, stall_cnt, flush_cnt, mem_err,
                 e.ctl, e.fa, e.fb, e.stall, e.flush, e.err);
      end
    end
  end

  initial begin
    in_t v;
    @(posedge clk);
    #1;

    // Reset quiets every control even with a forwarding match present.
    v = idle(); v.rst = 1'b1; v.exm_rw = 1'b1; v.exm_rd = 5'd7; v.idex_rs1 = 5'd7;
    step(v, mk("reset_outputs", C_RST, 2'b00, 2'b00, 0, 0, 1'b0));
    v = idle();
    step(v, mk("run_idle", C_RUN, 2'b00, 2'b00, 0, 0, 1'b0));

    // Load-use on rs1, then on rs2.
    v = idle(); v.memread = 1'b1; v.idex_rd = 5'd5; v.ifid_rs1 = 5'd5;
    step(v, mk("loaduse_rs1", C_LU, 2'b00, 2'b00, 0, 0, 1'b0));
    v = idle();
    step(v, mk("loaduse_after", C_RUN, 2'b00, 2'b00, 1, 0, 1'b0));
    v = idle(); v.memread = 1'b1; v.idex_rd = 5'd9; v.ifid_rs2 = 5'd9;
    step(v, mk("loaduse_rs2", C_LU, 2'b00, 2'b00, 1, 0, 1'b0));
    v = idle();
    step(v, mk("loaduse_rs2_after", C_RUN, 2'b00, 2'b00, 2, 0, 1'b0));

    // A load to x0 is never a hazard.
    v = idle(); v.memread = 1'b1; v.idex_rd = 5'd0; v.ifid_rs1 = 5'd0;
    step(v, mk("load_x0", C_RUN, 2'b00, 2'b00, 2, 0, 1'b0));
    v = idle();
    step(v, mk("load_x0_after", C_RUN, 2'b00, 2'b00, 2, 0, 1'b0));

    // Forwarding priority and x0 exclusion.
    v = idle(); v.exm_rw = 1'b1; v.exm_rd = 5'd7; v.mwb_rw = 1'b1; v.mwb_rd = 5'd7;
    v.idex_rs1 = 5'd7; v.idex_rs2 = 5'd7;
    step(v, mk("fwd_exmem_wins", C_RUN, 2'b10, 2'b10, 2, 0, 1'b0));
    v.exm_rw = 1'b0;
    step(v, mk("fwd_memwb", C_RUN, 2'b01, 2'b01, 2, 0, 1'b0));
    v = idle(); v.exm_rw = 1'b1; v.mwb_rw = 1'b1;
    step(v, mk("fwd_x0", C_RUN, 2'b00, 2'b00, 2, 0, 1'b0));
    v = idle(); v.exm_rw = 1'b1; v.exm_rd = 5'd3; v.mwb_rw = 1'b1; v.mwb_rd = 5'd4;
    v.idex_rs1 = 5'd3; v.idex_rs2 = 5'd4;
    step(v, mk("fwd_mixed", C_RUN, 2'b10, 2'b01, 2, 0, 1'b0));

    // Taken branch beats a simultaneous load-use.
    v = idle(); v.br = 1'b1; v.memread = 1'b1; v.idex_rd = 5'd5; v.ifid_rs1 = 5'd5;
    step(v, mk("branch_over_loaduse", C_BR, 2'b00, 2'b00, 2, 0, 1'b0));
    v = idle();
    step(v, mk("branch_after", C_RUN, 2'b00, 2'b00, 2, 1, 1'b0));

    // Memory wait of three frozen cycles, then ack; branch ignored while waiting.
    v = idle(); v.req = 1'b1; v.br = 1'b1; v.memread = 1'b1; v.idex_rd = 5'd5; v.ifid_rs1 = 5'd5;
    step(v, mk("memwait_1", C_FRZ, 2'b00, 2'b00, 2, 1, 1'b0));
    v = idle(); v.req = 1'b1; v.exm_rw = 1'b1; v.exm_rd = 5'd7; v.idex_rs1 = 5'd7;
    step(v, mk("memwait_2_fwd", C_FRZ, 2'b10, 2'b00, 3, 1, 1'b0));
    v = idle(); v.req = 1'b1;
    step(v, mk("memwait_3", C_FRZ, 2'b00, 2'b00, 4, 1, 1'b0));
    v.ack = 1'b1;
    step(v, mk("memwait_ack", C_RUN, 2'b00, 2'b00, 5, 1, 1'b0));
    v = idle();
    step(v, mk("memwait_back_run", C_RUN, 2'b00, 2'b00, 5, 1, 1'b0));

    // Watchdog: four wait cycles without ack trap into ERR.
    v = idle(); v.req = 1'b1;
    step(v, mk("timeout_w1", C_FRZ, 2'b00, 2'b00, 5, 1, 1'b0));
    step(v, mk("timeout_w2", C_FRZ, 2'b00, 2'b00, 6, 1, 1'b0));
    step(v, mk("timeout_w3", C_FRZ, 2'b00, 2'b00, 7, 1, 1'b0));
    step(v, mk("timeout_w4", C_FRZ, 2'b00, 2'b00, 8, 1, 1'b0));
    step(v, mk("err_state", C_FRZ, 2'b00, 2'b00, 9, 1, 1'b1));
    v.ack = 1'b1; v.br = 1'b1;
    step(v, mk("err_sticky", C_FRZ, 2'b00, 2'b00, 9, 1, 1'b1));
    v = idle(); v.rst = 1'b1;
    step(v, mk("err_reset", C_RST, 2'b00, 2'b00, 0, 0, 1'b0));
    v = idle();
    step(v, mk("err_reset_run", C_RUN, 2'b00, 2'b00, 0, 0, 1'b0));

    // Reset in the middle of a wait returns straight to RUN.
    v = idle(); v.req = 1'b1;
    step(v, mk("midwait_1", C_FRZ, 2'b00, 2'b00, 0, 0, 1'b0));
    step(v, mk("midwait_2", C_FRZ, 2'b00, 2'b00, 1, 0, 1'b0));
    v.rst = 1'b1;
    step(v, mk("midwait_reset", C_RST, 2'b00, 2'b00, 0, 0, 1'b0));
    v = idle();
    step(v, mk("midwait_run", C_RUN, 2'b00, 2'b00, 0, 0, 1'b0));

    // Let the monitor drain, with a bound.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
